// File: rtl/multi_button_event_debouncer.sv
// multi_button_event_debouncer: per-channel sync + debounce, press/release/long/repeat
// detection, and a lowest-channel-first valid/ready event port with sticky overflow.
module multi_button_event_debouncer #(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = 150000,
    parameter int LONG_CYCLES     = 3000000,
    parameter int REPEAT_CYCLES   = 600000,
    parameter bit REPEAT_EN       = 1'b1,
    parameter bit ACTIVE_LOW      = 1'b1,
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_raw,
    output logic [N_CH-1:0] btn_state,
    output logic [N_CH-1:0] btn_pressed,
    output logic [N_CH-1:0] btn_released,
    output logic [N_CH-1:0] btn_long,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [CH_W-1:0] evt_ch,
    output logic [1:0]      evt_type,
    output logic            evt_overflow
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int TM_W = $clog2(HOLD_MAX + 1);
    localparam int NB = N_CH * 4;
    localparam logic [N_CH-1:0] IDLE_LVL = {N_CH{ACTIVE_LOW}};

    typedef enum logic [1:0] {IDLE, WAIT_LONG, REPEAT, HELD} phase_t;

    logic [N_CH-1:0] sync1_q, sync1_d, sync2_q, sync2_d, level;
    logic [N_CH-1:0] state_q, state_d, pressed_q, pressed_d;
    logic [N_CH-1:0] released_q, released_d, long_q, long_d;
    logic [DB_W-1:0] db_cnt_q [N_CH];
    logic [DB_W-1:0] db_cnt_d [N_CH];
    logic [TM_W-1:0] timer_q [N_CH];
    logic [TM_W-1:0] timer_d [N_CH];
    phase_t          phase_q [N_CH];
    phase_t          phase_d [N_CH];
    logic [NB-1:0]   pending_q, pending_d, set_vec, clr;
    logic            evt_valid_q, evt_valid_d, overflow_q, overflow_d, load;
    logic [CH_W-1:0] evt_ch_q, evt_ch_d;
    logic [1:0]      evt_type_q, evt_type_d;
    int              sel;

    assign level = sync2_q ^ IDLE_LVL;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        state_d = state_q;
        pressed_d = '0;
        released_d = '0;
        long_d = '0;
        set_vec = '0;
        for (int c = 0; c < N_CH; c++) begin
            db_cnt_d[c] = (level[c] == state_q[c]) ? '0 : db_cnt_q[c] + DB_W'(1);
            if (level[c] != state_q[c] && db_cnt_q[c] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                db_cnt_d[c] = '0;
                state_d[c] = level[c];
                pressed_d[c] = level[c];
                released_d[c] = !level[c];
            end
            phase_d[c] = phase_q[c];
            timer_d[c] = (phase_q[c] == WAIT_LONG || phase_q[c] == REPEAT) ? timer_q[c] + TM_W'(1) : timer_q[c];
            // release takes priority over a LONG/REPEAT expiring on the same edge
            if (released_d[c]) begin
                phase_d[c] = IDLE;
                timer_d[c] = '0;
            end else if (pressed_d[c]) begin
                phase_d[c] = WAIT_LONG;
                timer_d[c] = '0;
            end else if (phase_q[c] == WAIT_LONG && timer_q[c] == TM_W'(LONG_CYCLES - 1)) begin
                long_d[c] = 1'b1;
                timer_d[c] = '0;
                phase_d[c] = REPEAT_EN ? REPEAT : HELD;
            end else if (phase_q[c] == REPEAT && timer_q[c] == TM_W'(REPEAT_CYCLES - 1)) begin
                set_vec[4*c+3] = 1'b1;
                timer_d[c] = '0;
            end
            set_vec[4*c+:3] = {long_d[c], released_d[c], pressed_d[c]};
        end
        sel = 0;
        for (int i = NB - 1; i >= 0; i--)
            if (pending_q[i]) sel = i;
        load = !evt_valid_q || evt_ready;
        clr = (load && |pending_q) ? NB'(1) << sel : '0;
        // a bit set on the edge it is consumed is re-pended rather than flagged as lost
        pending_d = (pending_q & ~clr) | set_vec;
        overflow_d = overflow_q || |(set_vec & pending_q & ~clr);
        evt_valid_d = load ? |pending_q : evt_valid_q;
        evt_ch_d = |clr ? CH_W'(sel / 4) : evt_ch_q;
        evt_type_d = |clr ? 2'(sel % 4) : evt_type_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= IDLE_LVL;
            sync2_q <= IDLE_LVL;
            state_q <= '0;
            pressed_q <= '0;
            released_q <= '0;
            long_q <= '0;
            db_cnt_q <= '{default: '0};
            timer_q <= '{default: '0};
            phase_q <= '{default: IDLE};
            pending_q <= '0;
            evt_valid_q <= 1'b0;
            overflow_q <= 1'b0;
            evt_ch_q <= '0;
            evt_type_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            pressed_q <= pressed_d;
            released_q <= released_d;
            long_q <= long_d;
            db_cnt_q <= db_cnt_d;
            timer_q <= timer_d;
            phase_q <= phase_d;
            pending_q <= pending_d;
            evt_valid_q <= evt_valid_d;
            overflow_q <= overflow_d;
            evt_ch_q <= evt_ch_d;
            evt_type_q <= evt_type_d;
        end
    end

    assign btn_state = state_q;
    assign btn_pressed = pressed_q;
    assign btn_released = released_q;
    assign btn_long = long_q;
    assign evt_valid = evt_valid_q;
    assign evt_ch = evt_ch_q;
    assign evt_type = evt_type_q;
    assign evt_overflow = overflow_q;
endmodule

// File: tb/tb_multi_button_event_debouncer.sv
// tb_multi_button_event_debouncer: directed scenarios plus random button/ready/reset traffic,
// checked every cycle against a window-and-elapsed-time reference model.
module tb_multi_button_event_debouncer;
    localparam int NC = 4, D = 8, L = 40, R = 10;

    logic          clk, rst, evt_ready, evt_valid, evt_overflow;
    logic [NC-1:0] btn_raw, btn_state, btn_pressed, btn_released, btn_long;
    logic [1:0]    evt_ch, evt_type;
    int            checks = 0, errors = 0;

    multi_button_event_debouncer #(
        .N_CH(NC), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .REPEAT_CYCLES(R),
        .REPEAT_EN(1'b1), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_state(btn_state),
        .btn_pressed(btn_pressed), .btn_released(btn_released), .btn_long(btn_long),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ch(evt_ch),
        .evt_type(evt_type), .evt_overflow(evt_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: hist holds pressed-normalised pin samples, [0] = previous edge.
    logic [D:0]    hist [NC];
    logic [NC-1:0] m_state, m_pr, m_rl, m_lg;
    logic [3:0]    m_pend [NC];
    logic [3:0]    m_set [NC];
    bit            m_hold [NC];
    int            m_pt [NC];
    logic          m_valid, m_ovf, m_flip, m_rep;
    int            m_ch, m_ty, t = 0, found, e;

    always @(posedge clk) begin
        t++;
        if (rst) begin
            for (int c = 0; c < NC; c++) begin
                hist[c] = '0;
                m_pend[c] = '0;
                m_hold[c] = 0;
                m_pt[c] = 0;
            end
            m_state = '0; m_pr = '0; m_rl = '0; m_lg = '0;
            m_valid = 0; m_ovf = 0; m_ch = 0; m_ty = 0;
        end else begin
            for (int c = 0; c < NC; c++) begin
                m_flip = 1;
                for (int k = 1; k <= D; k++)
                    if (hist[c][k] == m_state[c]) m_flip = 0;
                m_pr[c] = m_flip && !m_state[c];
                m_rl[c] = m_flip && m_state[c];
                if (m_flip) m_state[c] = !m_state[c];
                hist[c] = {hist[c][D-1:0], ~btn_raw[c]};
                m_lg[c] = 0;
                m_rep = 0;
                if (m_rl[c]) m_hold[c] = 0;
                else if (m_pr[c]) begin
                    m_hold[c] = 1;
                    m_pt[c] = t;
                end else if (m_hold[c]) begin
                    e = t - m_pt[c];
                    if (e == L) m_lg[c] = 1;
                    else if (e > L && (e - L) % R == 0) m_rep = 1;
                end
                m_set[c] = {m_rep, m_lg[c], m_rl[c], m_pr[c]};
            end
            found = -1;
            for (int c = 0; c < NC; c++)
                for (int ty = 0; ty < 4; ty++)
                    if (found < 0 && m_pend[c][ty]) found = c * 4 + ty;
            if (!m_valid || evt_ready) begin
                m_valid = found >= 0;
                if (found >= 0) begin
                    m_ch = found / 4;
                    m_ty = found % 4;
                    m_pend[m_ch][m_ty] = 0;
                end
            end
            for (int c = 0; c < NC; c++)
                for (int ty = 0; ty < 4; ty++)
                    if (m_set[c][ty]) begin
                        if (m_pend[c][ty]) m_ovf = 1;
                        m_pend[c][ty] = 1;
                    end
        end
    end

    always @(negedge clk) begin
        check("pins", {btn_state, btn_pressed, btn_released, btn_long}, {m_state, m_pr, m_rl, m_lg});
        check("evt_flags", {evt_valid, evt_overflow}, {m_valid, m_ovf});
        if (m_valid) check("evt_id", {evt_ch, evt_type}, {2'(m_ch), 2'(m_ty)});
    end

    int dur [NC];

    initial begin
        rst = 1'b1;
        btn_raw = '1;
        evt_ready = 1'b1;
        cycles(3);
        check("reset_out", {btn_state, btn_pressed, btn_released, btn_long, evt_valid, evt_overflow, evt_ch, evt_type}, '0);
        rst = 1'b0;
        cycles(2);
        // 1: ch0 press, state flips 9 edges after sync1 capture
        btn_raw[0] = 1'b0;
        cycles(9);
        check("t1_state_early", btn_state, 4'b0000);
        cycles(1);
        check("t1_state", btn_state, 4'b0001);
        check("t1_pressed", btn_pressed, 4'b0001);
        cycles(1);
        check("t1_pressed_gone", btn_pressed, 4'b0000);
        check("t1_evt", {evt_valid, evt_ch, evt_type}, {1'b1, 2'd0, 2'd0});
        btn_raw[0] = 1'b1;
        cycles(12);
        // 2: short glitch on ch1
        btn_raw[1] = 1'b0;
        cycles(5);
        btn_raw[1] = 1'b1;
        cycles(15);
        check("t2_state", btn_state, 4'b0000);
        check("t2_no_evt", evt_valid, 1'b0);
        // 3: ch2 long hold then release
        btn_raw[2] = 1'b0;
        cycles(10);
        check("t3_pressed", btn_pressed, 4'b0100);
        cycles(40);
        check("t3_long", btn_long, 4'b0100);
        cycles(1);
        check("t3_long_evt", {evt_valid, evt_ch, evt_type}, {1'b1, 2'd2, 2'd2});
        cycles(10);
        check("t3_rep_evt", {evt_valid, evt_ch, evt_type}, {1'b1, 2'd2, 2'd3});
        btn_raw[2] = 1'b1;
        cycles(10);
        check("t3_released", btn_released, 4'b0100);
        cycles(1);
        check("t3_rel_evt", {evt_valid, evt_ch, evt_type}, {1'b1, 2'd2, 2'd1});
        cycles(30);
        check("t3_quiet", evt_valid, 1'b0);
        // 4: simultaneous ch1/ch3 press with consumer stalled
        evt_ready = 1'b0;
        btn_raw[1] = 1'b0;
        btn_raw[3] = 1'b0;
        cycles(10);
        check("t4_pressed", btn_pressed, 4'b1010);
        cycles(1);
        check("t4_first", {evt_valid, evt_ch, evt_type}, {1'b1, 2'd1, 2'd0});
        cycles(4);
        check("t4_stable", {evt_valid, evt_ch, evt_type}, {1'b1, 2'd1, 2'd0});
        evt_ready = 1'b1;
        cycles(1);
        check("t4_second", {evt_valid, evt_ch, evt_type}, {1'b1, 2'd3, 2'd0});
        cycles(1);
        check("t4_drained", evt_valid, 1'b0);
        btn_raw[1] = 1'b1;
        btn_raw[3] = 1'b1;
        cycles(15);
        // 5: overflow with consumer stalled
        evt_ready = 1'b0;
        btn_raw[0] = 1'b0;
        cycles(10);
        btn_raw[0] = 1'b1;
        cycles(10);
        btn_raw[0] = 1'b0;
        cycles(10);
        check("t5_no_ovf", evt_overflow, 1'b0);
        btn_raw[0] = 1'b1;
        cycles(10);
        btn_raw[0] = 1'b0;
        cycles(10);
        check("t5_ovf", evt_overflow, 1'b1);
        evt_ready = 1'b1;
        btn_raw[0] = 1'b1;
        cycles(20);
        check("t5_ovf_sticky", evt_overflow, 1'b1);
        // 6: reset during REPEAT on ch2 and mid-debounce on ch1
        btn_raw[2] = 1'b0;
        cycles(65);
        btn_raw[1] = 1'b0;
        cycles(4);
        rst = 1'b1;
        cycles(1);
        check("t6_reset_out", {btn_state, btn_pressed, btn_released, btn_long, evt_valid, evt_overflow, evt_ch, evt_type}, '0);
        cycles(1);
        rst = 1'b0;
        cycles(9);
        check("t6_state_early", btn_state, 4'b0000);
        cycles(1);
        check("t6_state", btn_state, 4'b0110);
        check("t6_pressed", btn_pressed, 4'b0110);
        btn_raw = '1;
        cycles(20);
        // random traffic
        for (int c = 0; c < NC; c++) dur[c] = $urandom_range(0, 20);
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            for (int c = 0; c < NC; c++) begin
                if (dur[c] == 0) begin
                    btn_raw[c] = ~btn_raw[c];
                    dur[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : $urandom_range(9, 70);
                end else dur[c]--;
            end
            evt_ready = $urandom_range(0, 3) != 0;
            rst = $urandom_range(0, 799) == 0;
        end
        rst = 1'b0;
        cycles(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
